bcd_serial_converter: RTL and testbench
=======================================

# bcd_serial_converter

Sequential, parametrised binary-to-BCD converter. It uses shift-and-add-3 (double dabble), processing one input bit per clock under a start/busy/done handshake. It generalises the combinational three-digit converter to any input width and digit count, with selectable signed/unsigned input and an overflow flag. It sits between the datapath result registers and the seven-segment display drivers.

## Interface
- `BITS`, 10, input width in bits (≥2).
- `DIGITS`, 3, number of BCD output digits (≥1).
- `SIGNED`, 1, controls how `binary` is read: 1 = two's complement, 0 = unsigned.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `binary`  in  BITS  value to convert; sampled on the accepting edge only.
- `busy`  out  1  high from the accepting edge until the end of the DONE cycle.
- `done`  out  1  one-cycle pulse; `bcd`, `negative` and `overflow` are valid from this cycle on.
- `bcd`  out  4*DIGITS  packed digits; digit 0 (ones) is in bits [3:0].
- `negative`  out  1  sign of the last converted value; always 0 when SIGNED=0.
- `overflow`  out  1  magnitude of the last converted value exceeded 10^DIGITS−1.
- `blank`  out  DIGITS  leading-zero mask, one bit per digit (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT when `start`=1.
  - SHIFT → DONE after exactly BITS shift cycles.
  - DONE → IDLE unconditionally.
- Accept (IDLE with `start`=1):
  - Latch the magnitude into a BITS-wide shift register.
  - When SIGNED=1 and `binary[BITS-1]`=1: magnitude = ~(binary−1), and `neg_r`=1.
  - Otherwise: magnitude = `binary`, and `neg_r`=0.
  - Clear the working digit register, the sticky overflow bit and the bit counter.
- The most negative input (e.g. 10'h200) has magnitude 2^(BITS−1). This value fits unsigned in BITS bits and is converted correctly.
- Each SHIFT cycle, in order:
  1. Every working digit ≥5 gets +3.
  2. Shift {digits, magnitude} left by one.
  3. If the bit leaving the top digit is 1, set the sticky overflow bit.
  4. Increment the counter.
- Entering DONE: register the working digits into `bcd`, `neg_r` into `negative`, and the sticky bit into `overflow`. These outputs then hold until the next DONE.
- When `overflow`=1, `bcd` holds the low DIGITS digits of the true value, modulo 10^DIGITS.
- `start` in SHIFT or DONE is ignored; there is no queue. `binary` may change freely after the accepting edge.
- Arithmetic is unsigned throughout. Digit corrections operate on 4-bit fields, and a digit never exceeds 9 after the shift.

## Timing
- Reset values: FSM in IDLE; `busy`=0, `done`=0, `bcd`=0, `negative`=0, `overflow`=0, `blank`=0; internal registers cleared.
- If `start` is accepted at edge E:
  - `busy`=1 after E.
  - SHIFT occupies edges E+1 … E+BITS.
  - `done`=1 and the outputs are updated in the cycle after edge E+BITS.
  - `busy` drops after edge E+BITS+1.
- Total latency from accept to `done`: BITS+1 cycles.
- Throughput: one conversion per BITS+2 cycles. The earliest new accept is the IDLE cycle following DONE.
- Reset has priority over every other input and applies mid-operation: the next cycle is IDLE with all outputs at reset values, and no `done` pulse is emitted for the aborted conversion.
- `reset` and `start` high together: reset wins, and the start request is lost.

## Configuration
- `BCD_BLANK_EN` defined:
  - `blank[i]`=1 when digit i and every higher digit are zero, except that `blank[0]` is always 0.
  - `blank` is registered together with `bcd` on entry to DONE.
- `BCD_BLANK_EN` undefined:
  - `blank` is tied to 0 and no blanking logic is built.
  - All other behaviour is identical.

## Test plan
- **Reset idle:** hold `reset` 2 cycles, then release → `busy`=0, `done`=0, `bcd`=0, `negative`=0, `overflow`=0.
- **Positive value:** defaults, `binary`=10'd345, `start` pulsed at edge E → `done` after E+10 only, `bcd`=12'h345, `negative`=0, `overflow`=0, `busy` low after E+11.
- **Signed values:**
  - 10'h3FF → `bcd`=12'h001, `negative`=1.
  - 10'h200 → `bcd`=12'h512, `negative`=1.
  - Same inputs with SIGNED=0: 10'h3FF → 12'h023 with overflow; 10'h200 → 12'h512, `negative`=0.
- **Overflow:** DIGITS=2, SIGNED=0, `binary`=10'd100 → `overflow`=1, `bcd`=8'h00. Then `binary`=10'd99 → `overflow`=0, `bcd`=8'h99.
- **Ignored start and abort:**
  - Accept 10'd345, then assert `start` with 10'd7 during SHIFT → result 12'h345, and exactly one `done` pulse.
  - Assert `reset` on the 5th SHIFT cycle → IDLE and `bcd`=0 next cycle, no `done` pulse.
- **Blanking** (`BCD_BLANK_EN` defined): 10'd45 → `bcd`=12'h045, `blank`=3'b100; 10'd0 → `blank`=3'b110. With the macro undefined: `blank`=0 in both cases.

Source files
------------

// File: rtl/bcd_serial_converter_if.sv
// Handshake/result bundle for bcd_serial_converter.
// master : requester side (drives start/binary, observes results).
// slave  : converter side (samples start/binary, drives busy/done/bcd/
//          negative/overflow/blank).
interface bcd_serial_converter_if #(
  parameter int unsigned BITS   = 10,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [BITS-1:0]       binary;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negative;
  logic                  overflow;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, binary,
    input  busy, done, bcd, negative, overflow, blank
  );

  modport slave (
    input  start, binary,
    output busy, done, bcd, negative, overflow, blank
  );
endinterface

// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with optional two's-complement input and a sticky overflow flag.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : bcd_serial_converter_if.slave
//            start/binary in; busy/done/bcd/negative/overflow/blank out
//
// Parameters: BITS (input width, >=2), DIGITS (BCD digits, >=1),
//             SIGNED (1 = two's complement input, 0 = unsigned).
// Optional feature macro: BCD_BLANK_EN enables the leading-zero mask on
// bus.blank; without it bus.blank is tied to zero.
module bcd_serial_converter #(
  parameter int unsigned BITS   = 10,
  parameter int unsigned DIGITS = 3,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  bcd_serial_converter_if.slave  bus
);

  localparam int unsigned CW = $clog2(BITS + 1);
  localparam int unsigned DW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] mag_q, mag_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sticky_q, sticky_d;
  logic            neg_r_q, neg_r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   bcd_q, bcd_d;
  logic            negative_q, negative_d;
  logic            overflow_q, overflow_d;

  logic [DW-1:0]   adj_c;
  logic [DW-1:0]   dig_shf_c;
  logic            top_bit_c;
  logic            in_neg_c;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_c;
`endif

  // Datapath: add-3 correction, shift into digits, bit lost off the top.
  always_comb begin
    adj_c = dig_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
    dig_shf_c = {adj_c[DW-2:0], mag_q[BITS-1]};
    top_bit_c = adj_c[DW-1];
    in_neg_c  = SIGNED && bus.binary[BITS-1];
  end

`ifdef BCD_BLANK_EN
  // Leading-zero mask of the final digits; the ones digit is never blanked.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    blank_c  = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero   = all_zero && (dig_shf_c[4*i +: 4] == 4'd0);
      blank_c[i] = all_zero;
    end
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    neg_r_d    = neg_r_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
`ifdef BCD_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SHIFT;
          busy_d   = 1'b1;
          // Negation as ~(x-1); the most negative value maps to 2^(BITS-1).
          mag_d    = in_neg_c ? ~(bus.binary - BITS'(1)) : bus.binary;
          neg_r_d  = in_neg_c;
          dig_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
        end
      end
      SHIFT: begin
        dig_d    = dig_shf_c;
        mag_d    = {mag_q[BITS-2:0], 1'b0};
        sticky_d = sticky_q | top_bit_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(BITS - 1)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          bcd_d      = dig_shf_c;
          negative_d = neg_r_q;
          overflow_d = sticky_q | top_bit_c;
`ifdef BCD_BLANK_EN
          blank_d    = blank_c;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      neg_r_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      neg_r_q    <= neg_r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
`ifdef BCD_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.negative = negative_q;
  assign bus.overflow = overflow_q;
`ifdef BCD_BLANK_EN
  assign bus.blank    = blank_q;
`else
  assign bus.blank    = '0;
`endif

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Bench for bcd_serial_converter: three instances share one stimulus
// (10-bit signed/3 digits, unsigned/3 digits, unsigned/2 digits).
module tb_bcd_serial_converter;

  localparam int unsigned BITS = 10;

  typedef struct {
    logic [9:0]  bin;
    logic [11:0] b0; logic n0; logic o0;   // signed, 3 digits
    logic [11:0] b1; logic o1;             // unsigned, 3 digits
    logic [7:0]  b2; logic o2;             // unsigned, 2 digits
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] binary;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_serial_converter_if #(.BITS(10), .DIGITS(3)) if0 ();
  bcd_serial_converter_if #(.BITS(10), .DIGITS(3)) if1 ();
  bcd_serial_converter_if #(.BITS(10), .DIGITS(2)) if2 ();

  assign if0.start = start;  assign if0.binary = binary;
  assign if1.start = start;  assign if1.binary = binary;
  assign if2.start = start;  assign if2.binary = binary;

  bcd_serial_converter #(.BITS(10), .DIGITS(3), .SIGNED(1'b1)) u_dut0 (
    .clock(clk), .reset(reset), .bus(if0));
  bcd_serial_converter #(.BITS(10), .DIGITS(3), .SIGNED(1'b0)) u_dut1 (
    .clock(clk), .reset(reset), .bus(if1));
  bcd_serial_converter #(.BITS(10), .DIGITS(2), .SIGNED(1'b0)) u_dut2 (
    .clock(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int x, input int d);
    logic [11:0] r;
    int          v;
    r = '0;
    v = x;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: decimal arithmetic on the integer value of the input.
  function automatic vec_t model(input logic [9:0] v);
    vec_t m;
    int   u;
    int   mag;
    u     = int'(v);
    m.bin = v;
    m.n0  = v[9];
    mag   = v[9] ? 1024 - u : u;
    m.b0  = to_bcd(mag, 3);
    m.o0  = mag > 999;
    m.b1  = to_bcd(u, 3);
    m.o1  = u > 999;
    m.b2  = 8'(to_bcd(u, 2));
    m.o2  = u > 99;
    return m;
  endfunction

  function automatic logic [2:0] exp_blank(input logic [11:0] b, input int d);
    logic [2:0] r;
    r = '0;
`ifdef BCD_BLANK_EN
    begin
      logic all_zero;
      all_zero = 1'b1;
      for (int i = d - 1; i >= 1; i--) begin
        all_zero = all_zero && (b[4*i +: 4] == 4'd0);
        r[i] = all_zero;
      end
    end
`else
    if (d < 0) r = b[2:0];
`endif
    return r;
  endfunction

  // One conversion with per-cycle latency checks; optional start during SHIFT.
  task automatic run_conv(input vec_t e, input bit mid_start);
    logic [2:0] dn;
    @(posedge clk); #1;
    binary = e.bin;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    binary = 10'($urandom);
    chk("busy_after_accept", {29'd0, if0.busy, if1.busy, if2.busy}, 32'd7);
    chk("done_after_accept", {29'd0, if0.done, if1.done, if2.done}, 32'd0);
    dn = '0;
    for (int k = 1; k <= int'(BITS); k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k < int'(BITS)) begin
        dn = dn | {if0.done, if1.done, if2.done};
        if (mid_start && k == 3) begin
          start  = 1'b1;
          binary = 10'd7;
        end
      end
    end
    chk("done_early", {29'd0, dn}, 32'd0);
    chk("done_pulse", {29'd0, if0.done, if1.done, if2.done}, 32'd7);
    chk("busy_in_done", {29'd0, if0.busy, if1.busy, if2.busy}, 32'd7);
    chk("bcd_s3", {20'd0, if0.bcd}, {20'd0, e.b0});
    chk("neg_s3", {31'd0, if0.negative}, {31'd0, e.n0});
    chk("ovf_s3", {31'd0, if0.overflow}, {31'd0, e.o0});
    chk("blank_s3", {29'd0, if0.blank}, {29'd0, exp_blank(e.b0, 3)});
    chk("bcd_u3", {20'd0, if1.bcd}, {20'd0, e.b1});
    chk("neg_u3", {31'd0, if1.negative}, 32'd0);
    chk("ovf_u3", {31'd0, if1.overflow}, {31'd0, e.o1});
    chk("blank_u3", {29'd0, if1.blank}, {29'd0, exp_blank(e.b1, 3)});
    chk("bcd_u2", {24'd0, if2.bcd}, {24'd0, e.b2});
    chk("ovf_u2", {31'd0, if2.overflow}, {31'd0, e.o2});
    chk("blank_u2", {30'd0, if2.blank}, {29'd0, exp_blank({4'd0, e.b2}, 2)});
    @(posedge clk); #1;
    chk("done_cleared", {29'd0, if0.done, if1.done, if2.done}, 32'd0);
    chk("busy_cleared", {29'd0, if0.busy, if1.busy, if2.busy}, 32'd0);
    chk("bcd_held", {20'd0, if0.bcd}, {20'd0, e.b0});
  endtask

  vec_t tbl[10];

  initial begin
    logic [2:0] dn;
    //         bin      b0      n0    o0    b1      o1    b2     o2
    tbl[0] = '{10'd345, 12'h345, 1'b0, 1'b0, 12'h345, 1'b0, 8'h45, 1'b1};
    tbl[1] = '{10'h3FF, 12'h001, 1'b1, 1'b0, 12'h023, 1'b1, 8'h23, 1'b1};
    tbl[2] = '{10'h200, 12'h512, 1'b1, 1'b0, 12'h512, 1'b0, 8'h12, 1'b1};
    tbl[3] = '{10'd100, 12'h100, 1'b0, 1'b0, 12'h100, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{10'd99,  12'h099, 1'b0, 1'b0, 12'h099, 1'b0, 8'h99, 1'b0};
    tbl[5] = '{10'd45,  12'h045, 1'b0, 1'b0, 12'h045, 1'b0, 8'h45, 1'b0};
    tbl[6] = '{10'd0,   12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{10'h1FF, 12'h511, 1'b0, 1'b0, 12'h511, 1'b0, 8'h11, 1'b1};
    tbl[8] = '{10'h3E8, 12'h024, 1'b1, 1'b0, 12'h000, 1'b1, 8'h00, 1'b1};
    tbl[9] = '{10'd7,   12'h007, 1'b0, 1'b0, 12'h007, 1'b0, 8'h07, 1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    binary = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", {29'd0, if0.busy, if1.busy, if2.busy}, 32'd0);
    chk("rst_done", {29'd0, if0.done, if1.done, if2.done}, 32'd0);
    chk("rst_bcd", {20'd0, if0.bcd}, 32'd0);
    chk("rst_flags", {28'd0, if0.negative, if0.overflow, if1.overflow, if2.overflow}, 32'd0);
    chk("rst_blank", {29'd0, if0.blank}, 32'd0);

    for (int i = 0; i < 10; i++) run_conv(tbl[i], 1'b0);

    // start while shifting is ignored; result is the first value.
    run_conv(tbl[0], 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_requeue", {29'd0, if0.busy, if1.busy, if2.busy}, 32'd0);
    end

    // Reset on the 5th SHIFT cycle aborts without a done pulse.
    @(posedge clk); #1;
    binary = 10'd345;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {29'd0, if0.busy, if1.busy, if2.busy}, 32'd0);
    chk("abort_bcd", {20'd0, if0.bcd}, 32'd0);
    chk("abort_ovf", {31'd0, if2.overflow}, 32'd0);
    dn = '0;
    repeat (15) begin
      @(posedge clk); #1;
      dn = dn | {if0.done, if1.done, if2.done};
    end
    chk("abort_no_done", {29'd0, dn}, 32'd0);

    // reset and start together: start is lost.
    binary = 10'd345;
    start  = 1'b1;
    reset  = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {29'd0, if0.busy, if1.busy, if2.busy}, 32'd0);
    dn = '0;
    repeat (15) begin
      @(posedge clk); #1;
      dn = dn | {if0.done, if1.done, if2.done} | {if0.busy, if1.busy, if2.busy};
    end
    chk("rst_start_idle", {29'd0, dn}, 32'd0);

    // Random values against the decimal model.
    for (int n = 0; n < 150; n++) begin
      logic [9:0] v;
      v = 10'($urandom_range(0, 1023));
      run_conv(model(v), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
